// File: rtl/ram_responder.sv
// ram_responder: dual-write-port word memory with a registered client read port,
// a combinational bench port, sticky out-of-range flag and saturating access counters.
module ram_responder #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_0,
    output logic [WIDTH-1:0]  rdata_0,
    input  logic [ADDR_W-1:0] waddr_0,
    input  logic              wen_0,
    input  logic [WIDTH-1:0]  wdata_0,
    input  logic [ADDR_W-1:0] debug_addr,
    output logic [WIDTH-1:0]  debug_data,
    input  logic              debug_write_en,
    input  logic [ADDR_W-1:0] debug_write_addr,
    input  logic [WIDTH-1:0]  debug_write_data,
    output logic              oob_err,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LIM = ADDR_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             r_ok, w_ok, d_ok, dw_ok, c_wr, d_wr;
    logic [WIDTH-1:0] rd_next;

    // Full-width compares so aliased upper address bits never wrap into range
    assign r_ok  = raddr_0 < LIM;
    assign w_ok  = waddr_0 < LIM;
    assign d_ok  = debug_addr < LIM;
    assign dw_ok = debug_write_addr < LIM;
    assign c_wr  = wen_0 && w_ok && !rst;
    assign d_wr  = debug_write_en && dw_ok;

    assign debug_data = d_ok ? mem[debug_addr[AW-1:0]] : '0;

    // Write-through forwarding, bench port taking priority over the client port
    always_comb begin
        rd_next = '0;
        rd_next = !r_ok ? '0 :
                  (d_wr && debug_write_addr == raddr_0) ? debug_write_data :
                  (c_wr && waddr_0 == raddr_0) ? wdata_0 :
                  mem[raddr_0[AW-1:0]];
    end

    // Bench write is issued last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (c_wr)
            mem[waddr_0[AW-1:0]] <= wdata_0;
        if (d_wr)
            mem[debug_write_addr[AW-1:0]] <= debug_write_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_0  <= '0;
            oob_err  <= 1'b0;
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            rdata_0 <= rd_next;
            oob_err <= oob_err || !r_ok || (wen_0 && !w_ok);
            if (c_wr && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
            if (r_ok && rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed and randomized checks of ram_responder against a
// word-array reference model that applies the access rules cycle by cycle.
module tb_ram_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raddr_0, waddr_0, wdata_0, debug_addr, debug_write_addr, debug_write_data;
    logic        wen_0, debug_write_en;
    logic [31:0] rdata_0, debug_data;
    logic        oob_err;
    logic [15:0] wr_count, rd_count;

    int total = 0;
    int bad = 0;

    logic [31:0] m_mem [16];
    logic [31:0] m_rd;
    logic        m_oob;
    logic [15:0] m_wr, m_rc;

    always #5 clk = ~clk;

    ram_responder dut (
        .clk(clk), .rst(rst),
        .raddr_0(raddr_0), .rdata_0(rdata_0),
        .waddr_0(waddr_0), .wen_0(wen_0), .wdata_0(wdata_0),
        .debug_addr(debug_addr), .debug_data(debug_data),
        .debug_write_en(debug_write_en), .debug_write_addr(debug_write_addr),
        .debug_write_data(debug_write_data),
        .oob_err(oob_err), .wr_count(wr_count), .rd_count(rd_count)
    );

    // Advance model and DUT by one edge using the currently driven inputs
    task automatic cycle;
        logic [31:0] nrd;
        nrd = 32'd0;
        if (!rst && raddr_0 < 16) begin
            if (debug_write_en && debug_write_addr == raddr_0) nrd = debug_write_data;
            else if (wen_0 && waddr_0 == raddr_0) nrd = wdata_0;
            else nrd = m_mem[raddr_0[3:0]];
        end
        if (rst) begin
            m_oob = 1'b0;
            m_wr = 16'd0;
            m_rc = 16'd0;
        end else begin
            if (raddr_0 >= 16 || (wen_0 && waddr_0 >= 16)) m_oob = 1'b1;
            if (wen_0 && waddr_0 < 16 && m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
            if (raddr_0 < 16 && m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
            if (wen_0 && waddr_0 < 16) m_mem[waddr_0[3:0]] = wdata_0;
        end
        if (debug_write_en && debug_write_addr < 16) m_mem[debug_write_addr[3:0]] = debug_write_data;
        m_rd = nrd;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        rst = 1'b0;
        wen_0 = 1'b0;
        debug_write_en = 1'b0;
        raddr_0 = 32'd0;
    endtask

    task automatic test_reset;
        quiet();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            debug_write_en = 1'b1;
            debug_write_addr = i;
            debug_write_data = $urandom;
            cycle();
        end
        debug_write_en = 1'b0;
        total++; if (rdata_0 !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_0); end
        total++; if (oob_err !== 1'b0) begin bad++; $display("FAIL reset_oob got=%b exp=0", oob_err); end
        total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL reset_wr_count got=%h exp=0", wr_count); end
        total++; if (rd_count !== 16'd0) begin bad++; $display("FAIL reset_rd_count got=%h exp=0", rd_count); end
        debug_addr = 5;
        #1;
        total++; if (debug_data !== m_mem[5]) begin bad++; $display("FAIL reset_prefill got=%h exp=%h", debug_data, m_mem[5]); end
    endtask

    task automatic test_mem_survives_reset;
        quiet();
        debug_write_en = 1'b1;
        debug_write_addr = 10;
        debug_write_data = 15;
        cycle();
        debug_write_en = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        debug_addr = 10;
        #1;
        total++; if (debug_data !== 32'd15) begin bad++; $display("FAIL survive_data got=%h exp=15", debug_data); end
        total++; if (rdata_0 !== 32'd0) begin bad++; $display("FAIL survive_rdata got=%h exp=0", rdata_0); end
        total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL survive_wr_count got=%h exp=0", wr_count); end
    endtask

    task automatic test_read_write;
        quiet();
        raddr_0 = 10;
        cycle();
        total++; if (rdata_0 !== 32'd15) begin bad++; $display("FAIL read_rdata got=%h exp=15", rdata_0); end
        total++; if (rd_count !== 16'd1) begin bad++; $display("FAIL read_rd_count got=%h exp=1", rd_count); end
        wen_0 = 1'b1;
        waddr_0 = 12;
        wdata_0 = 15;
        cycle();
        wen_0 = 1'b0;
        debug_addr = 12;
        #1;
        total++; if (debug_data !== 32'd15) begin bad++; $display("FAIL write_data got=%h exp=15", debug_data); end
        total++; if (wr_count !== 16'd1) begin bad++; $display("FAIL write_wr_count got=%h exp=1", wr_count); end
    endtask

    task automatic test_collision;
        quiet();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wen_0 = 1'b1; waddr_0 = 3; wdata_0 = 7;
        debug_write_en = 1'b1; debug_write_addr = 3; debug_write_data = 9;
        raddr_0 = 3;
        cycle();
        quiet();
        debug_addr = 3;
        #1;
        total++; if (debug_data !== 32'd9) begin bad++; $display("FAIL collide_mem got=%h exp=9", debug_data); end
        total++; if (rdata_0 !== 32'd9) begin bad++; $display("FAIL collide_rdata got=%h exp=9", rdata_0); end
        total++; if (wr_count !== 16'd1) begin bad++; $display("FAIL collide_wr_count got=%h exp=1", wr_count); end
        wen_0 = 1'b1; waddr_0 = 6; wdata_0 = 32'h0BAD_CAFE; raddr_0 = 6;
        cycle();
        quiet();
        total++; if (rdata_0 !== 32'h0BAD_CAFE) begin bad++; $display("FAIL rdw_client got=%h exp=0badcafe", rdata_0); end
    endtask

    task automatic test_oob_read;
        logic [15:0] rc0;
        quiet();
        rc0 = m_rc;
        raddr_0 = 16;
        cycle();
        total++; if (rdata_0 !== 32'd0) begin bad++; $display("FAIL oobr_rdata got=%h exp=0", rdata_0); end
        total++; if (oob_err !== 1'b1) begin bad++; $display("FAIL oobr_flag got=%b exp=1", oob_err); end
        total++; if (rd_count !== rc0) begin bad++; $display("FAIL oobr_rd_count got=%h exp=%h", rd_count, rc0); end
        raddr_0 = 5;
        for (int i = 0; i < 5; i++) begin
            cycle();
            total++; if (oob_err !== 1'b1) begin bad++; $display("FAIL oobr_sticky cyc=%0d got=%b exp=1", i, oob_err); end
        end
        rst = 1'b1;
        cycle();
        total++; if (oob_err !== 1'b0) begin bad++; $display("FAIL oobr_clear got=%b exp=0", oob_err); end
    endtask

    task automatic test_oob_write;
        logic [31:0] m2;
        logic [15:0] wc0;
        quiet();
        m2 = m_mem[2];
        debug_write_en = 1'b1; debug_write_addr = 32'h0000_0012; debug_write_data = 32'hFFFF_FFFF;
        cycle();
        debug_write_en = 1'b0;
        total++; if (oob_err !== 1'b0) begin bad++; $display("FAIL oobd_flag got=%b exp=0", oob_err); end
        wc0 = m_wr;
        wen_0 = 1'b1; waddr_0 = 32'h1000_0002; wdata_0 = 5;
        cycle();
        wen_0 = 1'b0;
        debug_addr = 2;
        #1;
        total++; if (debug_data !== m2) begin bad++; $display("FAIL oobw_mem got=%h exp=%h", debug_data, m2); end
        total++; if (oob_err !== 1'b1) begin bad++; $display("FAIL oobw_flag got=%b exp=1", oob_err); end
        total++; if (wr_count !== wc0) begin bad++; $display("FAIL oobw_wr_count got=%h exp=%h", wr_count, wc0); end
        debug_addr = 32'h0000_0100;
        #1;
        total++; if (debug_data !== 32'd0) begin bad++; $display("FAIL oob_debug_read got=%h exp=0", debug_data); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 19) == 0);
            wen_0 = $urandom_range(0, 1);
            waddr_0 = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 17);
            wdata_0 = $urandom;
            raddr_0 = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 16);
            debug_write_en = ($urandom_range(0, 3) == 0);
            debug_write_addr = $urandom_range(0, 17);
            debug_write_data = $urandom;
            if ($urandom_range(0, 3) == 0) waddr_0 = raddr_0;
            if ($urandom_range(0, 3) == 0) debug_write_addr = raddr_0;
            cycle();
            total++; if (rdata_0 !== m_rd) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, rdata_0, m_rd); end
            total++; if (oob_err !== m_oob) begin bad++; $display("FAIL rnd_oob n=%0d got=%b exp=%b", n, oob_err, m_oob); end
            total++; if (wr_count !== m_wr) begin bad++; $display("FAIL rnd_wr_count n=%0d got=%h exp=%h", n, wr_count, m_wr); end
            total++; if (rd_count !== m_rc) begin bad++; $display("FAIL rnd_rd_count n=%0d got=%h exp=%h", n, rd_count, m_rc); end
            debug_addr = $urandom_range(0, 17);
            #1;
            total++;
            if (debug_data !== (debug_addr < 16 ? m_mem[debug_addr[3:0]] : 32'd0)) begin
                bad++;
                $display("FAIL rnd_debug n=%0d addr=%0d got=%h", n, debug_addr, debug_data);
            end
        end
    endtask

    task automatic test_saturation;
        quiet();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wen_0 = 1'b1;
        while (m_wr != 16'hFFFE) begin
            waddr_0 = {28'd0, m_wr[3:0]};
            wdata_0 = {16'd0, m_wr};
            cycle();
        end
        total++; if (wr_count !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", wr_count); end
        for (int i = 0; i < 3; i++) begin
            waddr_0 = i;
            cycle();
            total++; if (wr_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold i=%0d got=%h exp=ffff", i, wr_count); end
        end
        wen_0 = 1'b0;
    endtask

    initial begin
        waddr_0 = 0; wdata_0 = 0; debug_addr = 0;
        debug_write_addr = 0; debug_write_data = 0;
        m_rd = 0; m_oob = 0; m_wr = 0; m_rc = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        quiet();
        test_reset();
        test_mem_survives_reset();
        test_read_write();
        test_collision();
        test_oob_read();
        test_oob_write();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DEPTH, default 16: number of words; power of two, at least 2.
REQ-002 Parameter WIDTH, default 32: data width in bits.
REQ-003 Parameter ADDR_W, default 32: width of every address port.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port raddr_0, input, ADDR_W: client read address, sampled every cycle.
REQ-007 Port rdata_0, output, WIDTH: registered client read data.
REQ-008 Port waddr_0, input, ADDR_W: client write address.
REQ-009 Port wen_0, input, 1: client write enable.
REQ-010 Port wdata_0, input, WIDTH: client write data.
REQ-011 Port debug_addr, input, ADDR_W: bench read address.
REQ-012 Port debug_data, output, WIDTH: combinational bench read data.
REQ-013 Port debug_write_en, input, 1: bench write enable.
REQ-014 Port debug_write_addr, input, ADDR_W: bench write address.
REQ-015 Port debug_write_data, input, WIDTH: bench write data.
REQ-016 Port oob_err, output, 1: sticky flag for an out-of-range access.
REQ-017 Port wr_count, output, 16: saturating count of committed client writes.
REQ-018 Port rd_count, output, 16: saturating count of in-range client reads after reset.

Function
REQ-019 The block SHALL hold DEPTH words of WIDTH bits; an address is in range when its value is below DEPTH, with no truncation of upper bits.
REQ-020 Client write: when wen_0=1 and waddr_0 is in range, mem[waddr_0] SHALL take wdata_0 at the rising edge.
REQ-021 Bench write: when debug_write_en=1 and debug_write_addr is in range, the word SHALL be written at the rising edge; this applies regardless of rst.
REQ-022 Write collision: when both write ports target the same in-range address in one cycle, the bench write SHALL win; wr_count still increments.
REQ-023 Client read: rdata_0 SHALL equal mem[raddr_0] one cycle after raddr_0 is presented, giving a fixed latency of 1 and no enable.
REQ-024 Read-during-write: when raddr_0 matches a word being written that cycle, rdata_0 SHALL return the newly written value, using the bench value if both ports write.
REQ-025 An out-of-range raddr_0 SHALL yield rdata_0=0 next cycle and SHALL NOT increment rd_count.
REQ-026 An out-of-range client write or bench write SHALL be ignored with memory unchanged; a client one SHALL NOT increment wr_count.
REQ-027 debug_data SHALL equal mem[debug_addr] combinationally, reflecting writes committed at prior edges; it SHALL be 0 when debug_addr is out of range.
REQ-028 oob_err SHALL set at the edge after any out-of-range client read or client write (wen_0=1), and SHALL stay set until reset; bench-port addresses never set it.
REQ-029 wr_count SHALL increment per in-range client write and rd_count per in-range client read cycle (not in reset); both SHALL saturate at 16'hFFFF.

Reset
REQ-030 With rst=1 at an edge, rdata_0, oob_err, wr_count and rd_count SHALL become 0.
REQ-031 Reset SHALL NOT modify memory contents; words written before or during reset SHALL survive it.
REQ-032 Client writes and reads SHALL be ignored and uncounted during reset cycles; rdata_0 SHALL be 0 in the cycle after each reset edge.
REQ-033 Reset asserted while a client write is pending SHALL drop that write; the next post-reset cycle SHALL operate normally.

Verification
REQ-034 Bench write addr 10 data 15 with rst=0, then rst=1 for one edge -> debug_addr=10 reads 15; rdata_0=0, wr_count=0.
REQ-035 After reset, raddr_0=10 at an edge -> rdata_0=15 after that edge; rd_count=1; next, wen_0=1 waddr_0=12 wdata_0=15 -> debug_addr=12 reads 15, wr_count=1.
REQ-036 Same cycle: wen_0=1 waddr_0=3 wdata_0=7, debug_write_en=1 debug_write_addr=3 data 9, raddr_0=3 -> mem[3]=9, rdata_0=9 next cycle, wr_count=1.
REQ-037 raddr_0=16 (DEPTH=16) -> rdata_0=0, oob_err=1 and stays 1 after 5 in-range cycles; rd_count unchanged; rst clears oob_err to 0.
REQ-038 wen_0=1 waddr_0=32'h1000_0002 wdata_0=5 -> mem[2] unchanged, oob_err=1, wr_count unchanged.
REQ-039 Force wr_count to 16'hFFFE, then 3 in-range client writes -> wr_count=16'hFFFF and stays there.
